// File: rtl/matrix_row_reader.sv
// rtl/matrix_row_reader.sv - Avalon-MM row fetcher streaming ROWS words to a valid/ready consumer
module matrix_row_reader #(
    parameter int ROWS    = 8,
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    input  logic              waitrequest,
    input  logic [DATA_W-1:0] readdata,
    input  logic              readdatavalid,
    output logic [DATA_W-1:0] row_data,
    output logic [7:0]        row_idx,
    output logic              row_valid,
    input  logic              row_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_DATA,
        S_PUSH,
        S_DONE
    } state_t;

    // Counter must represent TIMEOUT-1 without overflow for any TIMEOUT in 1..65535.
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [7:0]       ROW_LAST = 8'(ROWS - 1);

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   base_q;
    logic [7:0]          row_q;
    logic [7:0]          row_nxt;
    logic [CNT_W-1:0]    cnt_q;
    logic                timed_out;
    logic                handshake;

    assign row_nxt   = row_q + 8'd1;
    // The edge that sees the counter at TIMEOUT-1 without data is the TIMEOUT-th empty wait cycle.
    assign timed_out = (state == S_WAIT_DATA) && !readdatavalid && (cnt_q == CNT_LAST);
    assign handshake = (state == S_PUSH) && row_valid && row_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; read is always asserted in REQ, so acceptance is just !waitrequest there
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (start) state_next = S_REQ;
            S_REQ:       if (!waitrequest) state_next = S_WAIT_DATA;
            S_WAIT_DATA: begin
                if (readdatavalid) begin
                    state_next = S_PUSH;
                end else if (timed_out) begin
                    state_next = S_DONE;
                end
            end
            S_PUSH:      if (handshake) state_next = (row_q == ROW_LAST) ? S_DONE : S_REQ;
            S_DONE:      state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    // Registered outputs and datapath; control outputs are decoded from the next state so they align with it
    always_ff @(posedge clk) begin
        if (reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            read      <= 1'b0;
            address   <= '0;
            row_data  <= '0;
            row_idx   <= '0;
            row_valid <= 1'b0;
            base_q    <= '0;
            row_q     <= '0;
            cnt_q     <= '0;
        end else begin
            busy <= (state_next != S_IDLE);
            done <= (state_next == S_DONE);
            read <= (state_next == S_REQ);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q  <= base_addr;
                        address <= base_addr;
                        row_q   <= '0;
                        error   <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (!waitrequest) cnt_q <= '0;
                end
                S_WAIT_DATA: begin
                    if (readdatavalid) begin
                        row_data  <= readdata;
                        row_idx   <= row_q;
                        row_valid <= 1'b1;
                    end else if (timed_out) begin
                        error <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_PUSH: begin
                    if (handshake) begin
                        row_valid <= 1'b0;
                        if (row_q != ROW_LAST) begin
                            row_q   <= row_nxt;
                            address <= base_q + ADDR_W'(row_nxt);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_row_reader.sv
// tb/tb_matrix_row_reader.sv - self-checking bench for matrix_row_reader
module tb_matrix_row_reader;

    localparam int          ROWS      = 8;
    localparam int          DATA_W    = 64;
    localparam int          ADDR_W    = 32;
    localparam int          TIMEOUT   = 64;
    localparam logic [63:0] DATA_BASE = 64'h1111_1111_0000_0000;

    logic              clk;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;
    logic [DATA_W-1:0] row_data;
    logic [7:0]        row_idx;
    logic              row_valid;
    logic              row_ready;

    matrix_row_reader #(
        .ROWS(ROWS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .busy(busy), .done(done), .error(error), .address(address), .read(read),
        .waitrequest(waitrequest), .readdata(readdata), .readdatavalid(readdatavalid),
        .row_data(row_data), .row_idx(row_idx), .row_valid(row_valid), .row_ready(row_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] base;
        int          wait_n;      // waitrequest cycles per request
        int          long_row;    // row held off with 30 waitrequest cycles, -1 none
        int          lat;         // cycles from acceptance to readdatavalid
        int          stall_row;   // row the consumer stalls on, -1 none
        int          stall_n;
        int          drop_row;    // row never answered in time, -1 none
        bit          mid_start;
        bit          stray;
        bit          rand_ready;
        bit          exp_error;
        int          exp_rows;
    } vec_t;

    function automatic vec_t mk(logic [31:0] b, int w, int lr, int lat, int sr, int sn, int dr,
                                bit ms, bit st, bit rr, bit ee, int er);
        vec_t v;
        v.base = b; v.wait_n = w; v.long_row = lr; v.lat = lat; v.stall_row = sr; v.stall_n = sn;
        v.drop_row = dr; v.mid_start = ms; v.stray = st; v.rand_ready = rr; v.exp_error = ee; v.exp_rows = er;
        return v;
    endfunction

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Responder / consumer state and transaction logs
    vec_t        cur;
    vec_t        vecs[6];
    logic [31:0] acc_addr[$];
    int          acc_edge[$];
    logic [7:0]  hs_idx[$];
    logic [63:0] hs_data[$];
    int          hs_edge[$];
    int          acc_n, hs_n, done_n, stable_err, addr_err, order_err;
    int          stall_left, req_hold, need, pend_edge;
    bit          stray_arm, req_active, pend, prev_hold;
    logic [31:0] req_addr;
    logic [63:0] pend_data, prev_data;
    logic [7:0]  prev_idx;

    // Avalon responder and downstream consumer, driven between clock edges
    initial begin
        waitrequest = 1'b1; readdatavalid = 1'b0; readdata = '0; row_ready = 1'b1;
        pend = 1'b0; req_active = 1'b0; prev_hold = 1'b0; stray_arm = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend = 1'b0; req_active = 1'b0; prev_hold = 1'b0;
                waitrequest = 1'b1; readdatavalid = 1'b0; row_ready = 1'b1;
            end else begin
                if (done) done_n++;
                if (prev_hold && (!row_valid || row_data !== prev_data || row_idx !== prev_idx)) stable_err++;
                if (cur.rand_ready) row_ready = ($urandom_range(0, 3) != 0);
                else if (row_valid && int'(row_idx) == cur.stall_row && stall_left > 0) begin
                    row_ready = 1'b0;
                    stall_left--;
                end else row_ready = 1'b1;
                prev_hold = row_valid && !row_ready;
                prev_data = row_data;
                prev_idx  = row_idx;
                if (row_valid && row_ready) begin
                    hs_idx.push_back(row_idx);
                    hs_data.push_back(row_data);
                    hs_edge.push_back(cyc + 1);
                    hs_n++;
                end
                readdatavalid = 1'b0;
                readdata = {$urandom, $urandom};
                if (pend && pend_edge == cyc + 1) begin
                    readdatavalid = 1'b1;
                    readdata = pend_data;
                    pend = 1'b0;
                end else if (stray_arm && row_valid) begin
                    readdatavalid = 1'b1;
                    readdata = 64'hDEAD_BEEF_DEAD_BEEF;
                    stray_arm = 1'b0;
                end
                if (read) begin
                    if (!req_active) begin
                        req_active = 1'b1;
                        req_hold = 0;
                        req_addr = address;
                        if (acc_n != hs_n) order_err++;
                    end else if (address !== req_addr) addr_err++;
                    need = (acc_n == cur.long_row) ? 30 : cur.wait_n;
                    if (req_hold < need) begin
                        waitrequest = 1'b1;
                        req_hold++;
                    end else begin
                        waitrequest = 1'b0;
                        req_active = 1'b0;
                        acc_addr.push_back(address);
                        acc_edge.push_back(cyc + 1);
                        pend = 1'b1;
                        pend_edge = cyc + 1 + ((acc_n == cur.drop_row) ? TIMEOUT + 6 : cur.lat);
                        pend_data = DATA_BASE + {32'h0, address};
                        acc_n++;
                    end
                end else begin
                    waitrequest = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    task automatic begin_fetch(input vec_t v);
        cur = v;
        acc_addr.delete(); acc_edge.delete(); hs_idx.delete(); hs_data.delete(); hs_edge.delete();
        acc_n = 0; hs_n = 0; done_n = 0; stable_err = 0; addr_err = 0; order_err = 0;
        stall_left = v.stall_n;
        stray_arm = v.stray;
        @(negedge clk);
        start = 1'b1;
        base_addr = v.base;
        @(negedge clk);
        start = 1'b0;
        base_addr = $urandom;
        check("start_outputs", 64'({busy, read, error, done, address}),
              64'({1'b1, 1'b1, 1'b0, 1'b0, v.base}));
    endtask

    task automatic finish_fetch(input vec_t v);
        bit seen = 1'b0;
        bit mid  = 1'b0;
        int done_e = 0;
        int mism;
        int n_acc_exp = (v.drop_row >= 0) ? v.drop_row + 1 : ROWS;
        for (int k = 0; k < 6000 && !seen; k++) begin
            @(negedge clk);
            if (v.mid_start && !mid && acc_n == 3) begin
                start = 1'b1;
                base_addr = 32'h5555_0000;
                mid = 1'b1;
            end else start = 1'b0;
            if (done) begin
                seen = 1'b1;
                done_e = cyc;
            end
        end
        start = 1'b0;
        check("done_seen", 64'(seen), 64'(1));
        @(negedge clk);
        check("done_one_cycle_busy_low", 64'({done, busy}), 64'(0));
        check("accept_count", 64'(acc_addr.size()), 64'(n_acc_exp));
        mism = 0;
        foreach (acc_addr[i]) if (acc_addr[i] !== v.base + 32'(i)) mism++;
        check("address_sequence", 64'(mism), 64'(0));
        check("row_count", 64'(hs_idx.size()), 64'(v.exp_rows));
        mism = 0;
        foreach (hs_idx[i]) begin
            if (hs_idx[i] !== 8'(i)) mism++;
            if (hs_data[i] !== DATA_BASE + {32'h0, v.base + 32'(i)}) mism++;
        end
        check("row_contents", 64'(mism), 64'(0));
        check("error_flag", 64'(error), 64'(v.exp_error));
        check("done_pulses", 64'(done_n), 64'(1));
        if (v.drop_row >= 0)
            check("timeout_latency", 64'((acc_edge.size() > v.drop_row) ? done_e - acc_edge[v.drop_row] : -1),
                  64'(TIMEOUT));
        else
            check("done_after_last_row", 64'((hs_edge.size() == ROWS) ? done_e - hs_edge[ROWS-1] : -1), 64'(0));
        if (v.stall_row < 0 && v.long_row < 0 && !v.rand_ready && v.drop_row < 0) begin
            mism = 0;
            for (int i = 0; i + 1 < acc_edge.size(); i++)
                if (acc_edge[i+1] - acc_edge[i] != v.lat + 2 + v.wait_n) mism++;
            check("accept_interval", 64'(mism), 64'(0));
        end
        check("protocol_stable", 64'(stable_err + addr_err + order_err), 64'(0));
        repeat ((v.drop_row >= 0) ? 20 : 3) @(negedge clk);
        check("idle_after", 64'({row_valid, busy, error, 8'(hs_idx.size())}),
              64'({1'b0, 1'b0, v.exp_error, 8'(v.exp_rows)}));
    endtask

    task automatic run_fetch(input vec_t v);
        begin_fetch(v);
        finish_fetch(v);
    endtask

    initial begin
        vec_t rv;
        vecs[0] = mk(32'h0000_0000, 2, -1, 12, -1,  0, -1, 1'b0, 1'b0, 1'b0, 1'b0, 8);
        vecs[1] = mk(32'h0000_0100, 2, -1, 12,  3, 20, -1, 1'b0, 1'b0, 1'b0, 1'b0, 8);
        vecs[2] = mk(32'h0000_0040, 0,  5,  3, -1,  0, -1, 1'b0, 1'b0, 1'b0, 1'b0, 8);
        vecs[3] = mk(32'h0000_0200, 1, -1,  5, -1,  0,  2, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        vecs[4] = mk(32'h0000_0300, 0, -1,  1, -1,  0, -1, 1'b0, 1'b0, 1'b0, 1'b0, 8);
        vecs[5] = mk(32'hFFFF_FFFE, 1, -1,  4, -1,  0, -1, 1'b1, 1'b1, 1'b0, 1'b0, 8);
        cur = vecs[0];
        reset = 1'b1;
        start = 1'b0;
        base_addr = '0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", 64'({busy, done, error, read, row_valid, row_idx}), 64'(0));
        check("reset_address", 64'(address), 64'(0));
        check("reset_row_data", row_data, 64'(0));
        reset = 1'b0;

        foreach (vecs[i]) run_fetch(vecs[i]);

        for (int r = 0; r < 6; r++) begin
            vec_t v;
            v.base = $urandom;
            v.wait_n = int'($urandom_range(0, 3));
            v.long_row = -1;
            v.lat = int'($urandom_range(1, 15));
            v.stall_row = -1;
            v.stall_n = 0;
            v.drop_row = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, ROWS - 1)) : -1;
            v.mid_start = 1'($urandom_range(0, 1));
            v.stray = 1'($urandom_range(0, 1));
            v.rand_ready = 1'b1;
            v.exp_error = (v.drop_row >= 0);
            v.exp_rows = (v.drop_row >= 0) ? v.drop_row : ROWS;
            run_fetch(v);
        end

        // Reset while row 4 is outstanding, then a clean refetch from row 0
        rv = mk(32'h0000_0080, 0, -1, 12, -1, 0, -1, 1'b0, 1'b0, 1'b0, 1'b0, 8);
        begin_fetch(rv);
        for (int k = 0; k < 2000 && acc_n < 5; k++) @(negedge clk);
        @(negedge clk);
        check("pre_reset_wait_data", 64'({busy, read, row_valid, row_idx}), 64'({1'b1, 1'b0, 1'b0, 8'd3}));
        reset = 1'b1;
        @(negedge clk);
        check("reset_mid_ctrl", 64'({busy, done, error, read, row_valid, row_idx}), 64'(0));
        check("reset_mid_address", 64'(address), 64'(0));
        check("reset_mid_row_data", row_data, 64'(0));
        @(negedge clk);
        reset = 1'b0;
        run_fetch(rv);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_row_reader.md
# matrix_row_reader

Avalon-MM read initiator that fetches a block of matrix rows from the ROM-backed row memory and streams each 64-bit row to a downstream consumer. On a `start` pulse it issues `ROWS` single-word reads at consecutive word addresses from `base_addr`, keeping at most one read outstanding. Each returned row is delivered through a one-entry valid/ready output buffer. The block sits between the row-memory responder and the compute datapath (MAC array / matrix-vector engine) and signals completion or a response timeout.

## Interface
- `ROWS`, 8: rows fetched per `start`; valid range 1..256.
- `DATA_W`, 64: row width, equal to the Avalon `readdata` width.
- `ADDR_W`, 32: Avalon address width.
- `TIMEOUT`, 64: maximum number of cycles allowed in WAIT_DATA without `readdatavalid`; valid range 1..65535.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a fetch; ignored unless the block is in IDLE.
- `base_addr`  in  ADDR_W  word address of row 0; sampled on accepted `start`.
- `busy`  out  1  high while the state is not IDLE.
- `done`  out  1  one-cycle pulse at the end of a fetch, whether it succeeded or failed.
- `error`  out  1  sticky timeout flag; cleared on the next accepted `start`.
- `address`  out  ADDR_W  Avalon read address.
- `read`  out  1  Avalon read request.
- `waitrequest`  in  1  Avalon responder busy.
- `readdata`  in  DATA_W  Avalon read data.
- `readdatavalid`  in  1  Avalon read-data qualifier.
- `row_data`  out  DATA_W  registered row payload.
- `row_idx`  out  8  index of the row in `row_data`, 0..ROWS-1.
- `row_valid`  out  1  `row_data` holds an undelivered row.
- `row_ready`  in  1  consumer accepts the row.

## Operation
- States: IDLE, REQ, WAIT_DATA, PUSH, DONE.
- IDLE, on `start`:
  - latch `base_addr`;
  - `row` = 0, clear `error`;
  - go to REQ.
- REQ:
  - `read` = 1, `address` = base + row (modulo 2^ADDR_W, wraps silently);
  - `address` is held stable while `waitrequest` = 1;
  - the request is accepted at a rising edge with `read` = 1 and `waitrequest` = 0; on acceptance go to WAIT_DATA and clear the timeout counter.
- WAIT_DATA:
  - `read` = 0;
  - on `readdatavalid`: capture `readdata` into `row_data`, set `row_idx` = row, set `row_valid` = 1, go to PUSH;
  - otherwise the counter increments; when the counter reaches TIMEOUT: set `error` = 1, go to DONE.
- PUSH: when `row_valid` and `row_ready` are both high, clear `row_valid`. Then:
  - if row == ROWS-1, go to DONE;
  - otherwise increment row and go to REQ.
- DONE: `done` = 1 for this cycle only; next state is IDLE.
- `readdatavalid` in any state other than WAIT_DATA is ignored; such data is dropped and not counted.
- `start` while `busy` is ignored; the fetch in progress is unaffected.
- A timeout abandons the remaining rows. Any late `readdatavalid` arriving afterwards is ignored.
- The counter is sized for TIMEOUT with no overflow. The `row` counter is 8 bits wide.

## Timing
- Reset values:
  - state IDLE;
  - `busy`, `done`, `error`, `read`, `row_valid` = 0;
  - `address`, `row_data`, `row_idx` = 0.
- All outputs are registered. There is no combinational path from an input to an output.
- `busy` rises on the cycle after `start` is sampled and falls on the cycle after DONE.
- `read` rises on the cycle after `start` is sampled.
- `read` falls on the cycle after acceptance, which gives exactly one accepted request per row.
- `row_valid` rises on the cycle after `readdatavalid` is sampled high.
- Throughput: one row per (responder latency + 2 + consumer stall) cycles.
- The next REQ begins on the cycle after the row handshake.
- `done` asserts on the cycle after the last row handshake or after the timeout edge.
- Reset asserted mid-fetch: all state returns to reset values on the next edge, and `read` drops at that edge.

## Test plan
- Nominal fetch: bench responder with waitrequest = 1 for 2 cycles and data 12 cycles after acceptance, returning readdata = 0x1111_1111_0000_0000 + address; base = 0x0, `row_ready` = 1 → addresses 0..7 each accepted exactly once; rows 0..7 delivered in order with matching data and `row_idx`; one `done` pulse; `error` = 0.
- Backpressure: hold `row_ready` = 0 for 20 cycles on row 3 → `row_data` and `row_idx` = 3 stay stable; no read issued for row 4 until the handshake; all 8 rows still correct.
- Waitrequest hold: responder holds `waitrequest` = 1 for 30 cycles on row 5 → `address` is stable at base+5 throughout; no timeout, because the counter runs only in WAIT_DATA.
- Timeout: responder never returns row 2, TIMEOUT = 64 → `error` = 1 and `done` pulse exactly 64 cycles after acceptance of row 2; `busy` = 0 afterwards. A new `start` clears `error` and completes normally.
- Wrap and ignore: base = 0xFFFF_FFFE → addresses FFFF_FFFE, FFFF_FFFF, 0..5. A `start` pulsed mid-fetch and a stray `readdatavalid` in PUSH → both have no effect on the address sequence or the data.
- Reset mid-fetch: assert `reset` during WAIT_DATA of row 4 → on the next edge all outputs return to reset values; a subsequent `start` refetches from row 0.
